// File: rtl/tluh_adapter_reg.sv
// TL-UH device port to single-cycle register interface bridge.
// Burst beats become consecutive word accesses; atomics are done as read-modify-write.

package tluh_pkg;

    parameter int unsigned TL_AW        = 32;
    parameter int unsigned TL_DW        = 32;
    parameter int unsigned TL_AIW       = 8;
    parameter int unsigned TL_DBW       = TL_DW / 8;
    parameter int unsigned TL_SZW       = 3;
    parameter int unsigned TL_BEATSMAXW = 6;

    parameter logic [2:0] OpPutFullData    = 3'h0;
    parameter logic [2:0] OpPutPartialData = 3'h1;
    parameter logic [2:0] OpArithmeticData = 3'h2;
    parameter logic [2:0] OpLogicalData    = 3'h3;
    parameter logic [2:0] OpGet            = 3'h4;
    parameter logic [2:0] OpIntent         = 3'h5;

    parameter logic [2:0] DAccessAck     = 3'h0;
    parameter logic [2:0] DAccessAckData = 3'h1;
    parameter logic [2:0] DHintAck       = 3'h2;

    typedef struct packed {
        logic                a_valid;
        logic [2:0]          a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                d_ready;
    } tluh_h2d_t;

    typedef struct packed {
        logic                d_valid;
        logic [2:0]          d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic                d_sink;
        logic [TL_DW-1:0]    d_data;
        logic                d_error;
        logic                a_ready;
    } tluh_d2h_t;

endpackage

module tluh_adapter_reg
    import tluh_pkg::*;
#(
    parameter  int unsigned RegAw = 8,
    parameter  int unsigned RegDw = 32,
    localparam int unsigned RegBw = RegDw / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  tluh_h2d_t               tl_i,
    output tluh_d2h_t               tl_o,
    output logic [TL_BEATSMAXW-1:0] intention_blocks_o,
    output logic                    intent_o,
    output logic                    ie_o,
    output logic                    re_o,
    output logic                    we_o,
    output logic [RegAw-1:0]        addr_o,
    output logic [RegDw-1:0]        wdata_o,
    output logic [RegBw-1:0]        be_o,
    input  logic [RegDw-1:0]        rdata_i,
    input  logic                    error_i
);

    localparam int unsigned      WordShift   = $clog2(RegBw);
    localparam logic [TL_SZW-1:0] WordShiftSz = TL_SZW'(WordShift);

    typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_e;

    state_e                  state_q;
    logic                    a_ready_q;
    logic                    d_valid_q;
    logic [2:0]              d_opcode_q;
    logic [RegDw-1:0]        d_data_q;
    logic                    d_error_q;
    logic [2:0]              opcode_q;
    logic [2:0]              param_q;
    logic [TL_SZW-1:0]       size_q;
    logic [TL_AIW-1:0]       source_q;
    logic [RegDw-1:0]        adata_q;
    logic [RegAw-1:0]        base_q;
    logic [TL_BEATSMAXW-1:0] beat_cnt_q;
    logic [TL_BEATSMAXW-1:0] beats_q;
    logic                    re_q;
    logic                    we_q;
    logic                    ie_q;
    logic                    intent_q;
    logic [TL_BEATSMAXW-1:0] blocks_q;
    logic [RegAw-1:0]        addr_q;
    logic [RegDw-1:0]        wdata_q;
    logic [RegBw-1:0]        be_q;

    logic                    accept;
    logic                    first_beat;
    logic                    last_beat;
    logic                    single_shot;
    logic [RegAw-1:0]        a_base;
    logic [RegAw-1:0]        beat_addr;
    logic [RegAw-1:0]        next_addr;
    logic [TL_BEATSMAXW-1:0] a_beats;
    logic [RegDw-1:0]        amo_new;
    logic                    amo_ok;
    logic                    unused_addr;

    assign accept     = tl_i.a_valid & a_ready_q;
    assign first_beat = (beat_cnt_q == '0);
    assign last_beat  = ((beat_cnt_q + TL_BEATSMAXW'(1)) >= beats_q);
    // Intent and unsupported opcodes always complete in one response.
    assign single_shot = (opcode_q == OpIntent) || (opcode_q > OpIntent);
    assign a_base     = {tl_i.a_address[RegAw-1:WordShift], {WordShift{1'b0}}};
    assign beat_addr  = first_beat ? a_base
                                   : base_q + (RegAw'(beat_cnt_q) << WordShift);
    assign next_addr  = base_q + (RegAw'(beat_cnt_q + TL_BEATSMAXW'(1)) << WordShift);
    assign unused_addr = ^{tl_i.a_address[TL_AW-1:RegAw], tl_i.a_address[WordShift-1:0]};

    always_comb begin
        a_beats = TL_BEATSMAXW'(1);
        if (tl_i.a_size > WordShiftSz) begin
            a_beats = TL_BEATSMAXW'(1) << (tl_i.a_size - WordShiftSz);
        end
    end

    // Old value comes straight from rdata_i while the read strobe is up.
    always_comb begin
        amo_new = rdata_i;
        amo_ok  = 1'b1;
        if (opcode_q == OpArithmeticData) begin
            case (param_q)
                3'd0: amo_new = ($signed(rdata_i) < $signed(adata_q)) ? rdata_i : adata_q;
                3'd1: amo_new = ($signed(rdata_i) > $signed(adata_q)) ? rdata_i : adata_q;
                3'd2: amo_new = (rdata_i < adata_q) ? rdata_i : adata_q;
                3'd3: amo_new = (rdata_i > adata_q) ? rdata_i : adata_q;
                3'd4: amo_new = rdata_i + adata_q;
                default: amo_ok = 1'b0;
            endcase
        end else begin
            case (param_q)
                3'd0: amo_new = rdata_i ^ adata_q;
                3'd1: amo_new = rdata_i | adata_q;
                3'd2: amo_new = rdata_i & adata_q;
                3'd3: amo_new = adata_q;
                default: amo_ok = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            a_ready_q  <= 1'b1;
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
            opcode_q   <= '0;
            param_q    <= '0;
            size_q     <= '0;
            source_q   <= '0;
            adata_q    <= '0;
            base_q     <= '0;
            beat_cnt_q <= '0;
            beats_q    <= '0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            ie_q       <= 1'b0;
            intent_q   <= 1'b0;
            blocks_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            ie_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        opcode_q  <= tl_i.a_opcode;
                        param_q   <= tl_i.a_param;
                        size_q    <= tl_i.a_size;
                        source_q  <= tl_i.a_source;
                        adata_q   <= tl_i.a_data;
                        a_ready_q <= 1'b0;
                        if (first_beat) begin
                            base_q  <= a_base;
                            beats_q <= a_beats;
                        end
                        state_q <= StAccess;
                        case (tl_i.a_opcode)
                            OpGet, OpArithmeticData, OpLogicalData: begin
                                re_q   <= 1'b1;
                                addr_q <= beat_addr;
                                be_q   <= tl_i.a_mask;
                            end
                            OpPutFullData, OpPutPartialData: begin
                                we_q    <= 1'b1;
                                addr_q  <= beat_addr;
                                wdata_q <= tl_i.a_data;
                                be_q    <= (tl_i.a_opcode == OpPutFullData) ? '1 : tl_i.a_mask;
                            end
                            OpIntent: begin
                                ie_q     <= 1'b1;
                                intent_q <= tl_i.a_param[0];
                                blocks_q <= a_beats;
                            end
                            default: begin
                                state_q    <= StResp;
                                d_valid_q  <= 1'b1;
                                d_opcode_q <= DAccessAck;
                                d_data_q   <= '0;
                                d_error_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                StAccess: begin
                    re_q    <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= StResp;
                    case (opcode_q)
                        OpGet: begin
                            d_valid_q  <= 1'b1;
                            d_opcode_q <= DAccessAckData;
                            d_data_q   <= rdata_i;
                            d_error_q  <= error_i;
                        end
                        OpPutFullData, OpPutPartialData: begin
                            d_valid_q  <= 1'b1;
                            d_opcode_q <= DAccessAck;
                            d_data_q   <= '0;
                            d_error_q  <= error_i;
                        end
                        OpArithmeticData, OpLogicalData: begin
                            d_opcode_q <= DAccessAckData;
                            d_data_q   <= rdata_i;
                            if (error_i || !amo_ok) begin
                                d_valid_q <= 1'b1;
                                d_error_q <= 1'b1;
                            end else begin
                                we_q    <= 1'b1;
                                wdata_q <= amo_new;
                                state_q <= StWrite;
                            end
                        end
                        OpIntent: begin
                            d_valid_q  <= 1'b1;
                            d_opcode_q <= DHintAck;
                            d_data_q   <= '0;
                            d_error_q  <= 1'b0;
                        end
                        default: begin
                            d_valid_q  <= 1'b1;
                            d_opcode_q <= DAccessAck;
                            d_data_q   <= '0;
                            d_error_q  <= 1'b1;
                        end
                    endcase
                end
                StWrite: begin
                    we_q      <= 1'b0;
                    d_valid_q <= 1'b1;
                    d_error_q <= error_i;
                    state_q   <= StResp;
                end
                StResp: begin
                    if (tl_i.d_ready) begin
                        d_valid_q <= 1'b0;
                        if (single_shot || last_beat) begin
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + TL_BEATSMAXW'(1);
                        end
                        // Get bursts need no further A beats; others wait for the next one.
                        if (opcode_q == OpGet && !last_beat) begin
                            re_q    <= 1'b1;
                            addr_q  <= next_addr;
                            state_q <= StAccess;
                        end else begin
                            a_ready_q <= 1'b1;
                            state_q   <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    a_ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready_q;
        tl_o.d_valid  = d_valid_q;
        tl_o.d_opcode = d_opcode_q;
        tl_o.d_param  = '0;
        tl_o.d_size   = size_q;
        tl_o.d_source = source_q;
        tl_o.d_sink   = 1'b0;
        tl_o.d_data   = d_data_q;
        tl_o.d_error  = d_error_q;
    end

    assign intention_blocks_o = blocks_q;
    assign intent_o           = intent_q;
    assign ie_o               = ie_q;
    assign re_o               = re_q;
    assign we_o               = we_q;
    assign addr_o             = addr_q;
    assign wdata_o            = wdata_q;
    assign be_o               = be_q;

endmodule

// File: tb/tb_tluh_adapter_reg.sv
// Directed bench for tluh_adapter_reg with a small register-file model on the reg side.

module tb_tluh_adapter_reg;
    import tluh_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    tluh_h2d_t   tl_h2d;
    tluh_d2h_t   tl_d2h;
    logic [5:0]  blocks;
    logic        intent;
    logic        ie;
    logic        re;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
    logic        err_force = 1'b0;

    logic [31:0] mem [0:63];
    logic [31:0] re_addrs [$];
    logic [31:0] we_addrs [$];
    logic [31:0] we_datas [$];
    logic [3:0]  we_bes   [$];
    int          ie_cnt;
    logic [5:0]  ie_blocks;
    logic        ie_intent;
    logic        both_seen = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    tluh_adapter_reg #(.RegAw(8), .RegDw(32)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .tl_i               (tl_h2d),
        .tl_o               (tl_d2h),
        .intention_blocks_o (blocks),
        .intent_o           (intent),
        .ie_o               (ie),
        .re_o               (re),
        .we_o               (we),
        .addr_o             (addr),
        .wdata_o            (wdata),
        .be_o               (be),
        .rdata_i            (rdata),
        .error_i            (err)
    );

    assign rdata = mem[addr[7:2]];
    assign err   = err_force;

    always @(posedge clk_i) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    always @(negedge clk_i) begin
        if (re) re_addrs.push_back({24'h0, addr});
        if (we) begin
            we_addrs.push_back({24'h0, addr});
            we_datas.push_back(wdata);
            we_bes.push_back(be);
        end
        if (re && we) both_seen = 1'b1;
        if (ie) begin
            ie_cnt++;
            ie_blocks = blocks;
            ie_intent = intent;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_logs();
        re_addrs.delete();
        we_addrs.delete();
        we_datas.delete();
        we_bes.delete();
        ie_cnt = 0;
    endtask

    task automatic send_a(input string tag, input logic [2:0] op, input logic [2:0] param,
                          input logic [2:0] size, input logic [7:0] src,
                          input logic [31:0] address, input logic [3:0] mask,
                          input logic [31:0] data);
        logic ok;
        ok = 1'b0;
        tl_h2d.a_valid   = 1'b1;
        tl_h2d.a_opcode  = op;
        tl_h2d.a_param   = param;
        tl_h2d.a_size    = size;
        tl_h2d.a_source  = src;
        tl_h2d.a_address = address;
        tl_h2d.a_mask    = mask;
        tl_h2d.a_data    = data;
        for (int i = 0; i < 40; i++) begin
            if (tl_d2h.a_ready) begin
                @(posedge clk_i);
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        #1;
        tl_h2d.a_valid = 1'b0;
        chk({tag, "_accept"}, ok, 1);
    endtask

    task automatic expect_d(input string tag, input int stall, input int lat,
                            input logic [2:0] op, input logic [31:0] data, input logic derr,
                            input logic [2:0] size, input logic [7:0] src);
        logic seen;
        int   waits;
        seen  = 1'b0;
        waits = 0;
        if (stall > 0) tl_h2d.d_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            waits++;
            if (tl_d2h.d_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_dvalid"}, seen, 1);
        if (seen) begin
            if (lat > 0) chk({tag, "_latency"}, waits, lat);
            if (stall > 0) begin
                repeat (stall) @(negedge clk_i);
                chk({tag, "_hold"}, tl_d2h.d_valid, 1);
            end
            chk({tag, "_opcode"}, tl_d2h.d_opcode, op);
            chk({tag, "_data"}, tl_d2h.d_data, data);
            chk({tag, "_error"}, tl_d2h.d_error, derr);
            chk({tag, "_size"}, tl_d2h.d_size, size);
            chk({tag, "_source"}, tl_d2h.d_source, src);
            chk({tag, "_param"}, tl_d2h.d_param, 0);
            tl_h2d.d_ready = 1'b1;
            @(posedge clk_i);
            #1;
        end else begin
            tl_h2d.d_ready = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        tl_h2d         = '0;
        tl_h2d.d_ready = 1'b1;
        rst_ni         = 1'b0;
        clr_logs();
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        chk("rst_a_ready", tl_d2h.a_ready, 1);
        chk("rst_d_valid", tl_d2h.d_valid, 0);
        chk("rst_strobes", {re, we, ie, intent}, 0);
        chk("rst_addr_be", {addr, be, blocks}, 0);
        chk("rst_d_fields", {tl_d2h.d_opcode, tl_d2h.d_data, tl_d2h.d_error}, 0);

        // single Get, with D stalled to see d_valid hold
        mem[0] = 32'd17; mem[1] = 32'd1; mem[2] = 32'd2;
        clr_logs();
        send_a("get1", OpGet, 3'd0, 3'd2, 8'd0, 32'h0, 4'hf, 32'h0);
        expect_d("get1", 3, 2, DAccessAckData, 32'd17, 1'b0, 3'd2, 8'd0);
        chk("get1_re_n", re_addrs.size(), 1);
        chk("get1_re_addr", re_addrs[0], 32'h0);

        // two-beat Get from one A beat
        clr_logs();
        send_a("get2", OpGet, 3'd0, 3'd3, 8'd3, 32'h4, 4'hf, 32'h0);
        expect_d("get2_b0", 0, 2, DAccessAckData, 32'd1, 1'b0, 3'd3, 8'd3);
        expect_d("get2_b1", 0, 2, DAccessAckData, 32'd2, 1'b0, 3'd3, 8'd3);
        chk("get2_re_n", re_addrs.size(), 2);
        chk("get2_re_a0", re_addrs[0], 32'h4);
        chk("get2_re_a1", re_addrs[1], 32'h8);

        // PutFullData forces all byte enables even with a zero mask
        clr_logs();
        send_a("put1", OpPutFullData, 3'd0, 3'd2, 8'd1, 32'hc, 4'h0, 32'd55);
        expect_d("put1", 0, 2, DAccessAck, 32'h0, 1'b0, 3'd2, 8'd1);
        chk("put1_we_addr", we_addrs[0], 32'hc);
        chk("put1_we_data", we_datas[0], 32'd55);
        chk("put1_we_be", we_bes[0], 4'hf);
        chk("put1_mem", mem[3], 32'd55);

        // two-beat Put; second beat's address is ignored
        clr_logs();
        mem[16] = 32'd123;
        send_a("put2_b0", OpPutFullData, 3'd0, 3'd3, 8'd1, 32'h4, 4'hf, 32'd66);
        expect_d("put2_b0", 0, 2, DAccessAck, 32'h0, 1'b0, 3'd3, 8'd1);
        send_a("put2_b1", OpPutFullData, 3'd0, 3'd3, 8'd1, 32'h40, 4'hf, 32'd77);
        expect_d("put2_b1", 0, 2, DAccessAck, 32'h0, 1'b0, 3'd3, 8'd1);
        chk("put2_we_n", we_addrs.size(), 2);
        chk("put2_we_a0", we_addrs[0], 32'h4);
        chk("put2_we_a1", we_addrs[1], 32'h8);
        chk("put2_we_d0", we_datas[0], 32'd66);
        chk("put2_we_d1", we_datas[1], 32'd77);
        chk("put2_mem40", mem[16], 32'd123);

        // PutPartialData keeps the mask
        clr_logs();
        mem[5] = 32'h11223344;
        send_a("pp", OpPutPartialData, 3'd0, 3'd2, 8'd2, 32'h14, 4'h3, 32'haabbccdd);
        expect_d("pp", 0, 2, DAccessAck, 32'h0, 1'b0, 3'd2, 8'd2);
        chk("pp_mem", mem[5], 32'h1122ccdd);

        // Arithmetic MIN: latency 3, returns old value
        clr_logs();
        mem[1] = 32'd1; mem[2] = 32'd2;
        send_a("min", OpArithmeticData, 3'd0, 3'd2, 8'd4, 32'h4, 4'hf, 32'd0);
        expect_d("min", 0, 3, DAccessAckData, 32'd1, 1'b0, 3'd2, 8'd4);
        chk("min_we_n", we_addrs.size(), 1);
        chk("min_we", {we_addrs[0], we_datas[0]}, {32'h4, 32'd0});

        // Arithmetic MAX two-beat burst
        clr_logs();
        mem[1] = 32'd1; mem[2] = 32'd2;
        send_a("max_b0", OpArithmeticData, 3'd1, 3'd3, 8'd4, 32'h4, 4'hf, 32'd5);
        expect_d("max_b0", 0, 3, DAccessAckData, 32'd1, 1'b0, 3'd3, 8'd4);
        send_a("max_b1", OpArithmeticData, 3'd1, 3'd3, 8'd4, 32'h0, 4'hf, 32'd1);
        expect_d("max_b1", 0, 3, DAccessAckData, 32'd2, 1'b0, 3'd3, 8'd4);
        chk("max_we0", {we_addrs[0], we_datas[0]}, {32'h4, 32'd5});
        chk("max_we1", {we_addrs[1], we_datas[1]}, {32'h8, 32'd2});

        // signed MIN with -1, ADD wrap, XOR
        clr_logs();
        mem[1] = 32'd1; mem[2] = 32'hffffffff; mem[3] = 32'h0f;
        send_a("mins", OpArithmeticData, 3'd0, 3'd2, 8'd0, 32'h4, 4'hf, 32'hffffffff);
        expect_d("mins", 0, 3, DAccessAckData, 32'd1, 1'b0, 3'd2, 8'd0);
        chk("mins_mem", mem[1], 32'hffffffff);
        send_a("add", OpArithmeticData, 3'd4, 3'd2, 8'd0, 32'h8, 4'hf, 32'd1);
        expect_d("add", 0, 3, DAccessAckData, 32'hffffffff, 1'b0, 3'd2, 8'd0);
        chk("add_mem", mem[2], 32'h0);
        send_a("xor", OpLogicalData, 3'd0, 3'd2, 8'd0, 32'hc, 4'hf, 32'hff);
        expect_d("xor", 0, 3, DAccessAckData, 32'h0f, 1'b0, 3'd2, 8'd0);
        chk("xor_mem", mem[3], 32'hf0);

        // undefined arithmetic param: no write, error
        clr_logs();
        mem[1] = 32'd1;
        send_a("badp", OpArithmeticData, 3'd6, 3'd2, 8'd0, 32'h4, 4'hf, 32'd9);
        expect_d("badp", 0, 2, DAccessAckData, 32'd1, 1'b1, 3'd2, 8'd0);
        chk("badp_we_n", we_addrs.size(), 0);
        chk("badp_mem", mem[1], 32'd1);

        // error_i during atomic read skips the write; error on Get
        clr_logs();
        err_force = 1'b1;
        send_a("amoerr", OpLogicalData, 3'd1, 3'd2, 8'd0, 32'h4, 4'hf, 32'hf0);
        expect_d("amoerr", 0, 2, DAccessAckData, 32'd1, 1'b1, 3'd2, 8'd0);
        chk("amoerr_we_n", we_addrs.size(), 0);
        send_a("geterr", OpGet, 3'd0, 3'd2, 8'd0, 32'h4, 4'hf, 32'h0);
        expect_d("geterr", 0, 2, DAccessAckData, 32'd1, 1'b1, 3'd2, 8'd0);
        err_force = 1'b0;

        // Intents
        clr_logs();
        send_a("int0", OpIntent, 3'd0, 3'd2, 8'd6, 32'h0, 4'hf, 32'h0);
        expect_d("int0", 0, 2, DHintAck, 32'h0, 1'b0, 3'd2, 8'd6);
        chk("int0_ie_cnt", ie_cnt, 1);
        chk("int0_blocks", ie_blocks, 6'd1);
        chk("int0_intent", ie_intent, 0);
        chk("int0_no_access", re_addrs.size() + we_addrs.size(), 0);
        clr_logs();
        send_a("int1", OpIntent, 3'd1, 3'd4, 8'd6, 32'h0, 4'hf, 32'h0);
        expect_d("int1", 0, 2, DHintAck, 32'h0, 1'b0, 3'd4, 8'd6);
        chk("int1_ie", {ie_cnt[7:0], 1'b0, ie_intent, ie_blocks}, {8'd1, 1'b0, 1'b1, 6'd4});

        // unsupported opcode
        clr_logs();
        send_a("badop", 3'd7, 3'd0, 3'd2, 8'd9, 32'h0, 4'hf, 32'h0);
        expect_d("badop", 0, 1, DAccessAck, 32'h0, 1'b1, 3'd2, 8'd9);
        chk("badop_no_access", re_addrs.size() + we_addrs.size(), 0);

        // reset mid-burst: drop the second beat and clear the beat counter
        mem[1] = 32'd1; mem[2] = 32'd2; mem[3] = 32'd33;
        send_a("rstb", OpGet, 3'd0, 3'd3, 8'd0, 32'h4, 4'hf, 32'h0);
        expect_d("rstb_b0", 0, 2, DAccessAckData, 32'd1, 1'b0, 3'd3, 8'd0);
        rst_ni = 1'b0;
        #1;
        chk("rstb_d_valid", tl_d2h.d_valid, 0);
        chk("rstb_a_ready", tl_d2h.a_ready, 1);
        chk("rstb_re", re, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        send_a("after", OpGet, 3'd0, 3'd2, 8'd2, 32'hc, 4'hf, 32'h0);
        expect_d("after", 0, 2, DAccessAckData, 32'd33, 1'b0, 3'd2, 8'd2);

        chk("re_we_exclusive", both_seen, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tluh_adapter_reg.md
Name: tluh_adapter_reg

Overview:
- Bridges a TileLink TL-UH device port to a simple single-cycle register-file interface (re/we/addr/wdata/be/rdata/error).
- Sits in front of peripheral register blocks, e.g. GPIO.
- Supports Get, PutFullData, PutPartialData, ArithmeticData, LogicalData and Intent, including multi-beat bursts.
- Burst beats become consecutive word accesses.

Parameters:
- RegAw, 8: register address width.
- RegDw, 32: register data width; must equal TL_DW.
- RegBw, RegDw/8 (localparam): bytes per beat.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- tl_i  in  tluh_h2d_t  TL-UH A channel plus d_ready.
- tl_o  out  tluh_d2h_t  TL-UH D channel plus a_ready.
- intention_blocks_o  out  TL_BEATSMAXW  number of RegBw blocks covered by the current Intent.
- intent_o  out  1  Intent type: 0 = PrefetchRead (a_param 0), 1 = PrefetchWrite (a_param 1).
- ie_o  out  1  one-cycle intent strobe.
- re_o  out  1  register read enable.
- we_o  out  1  register write enable.
- addr_o  out  RegAw  word-aligned register byte address.
- wdata_o  out  RegDw  write data.
- be_o  out  RegBw  byte enables.
- rdata_i  in  RegDw  read data, combinational, valid while re_o=1.
- error_i  in  1  access error, sampled with re_o/we_o.

Behaviour:
- Reset values: state IDLE, a_ready=1, d_valid=0, and re_o, we_o, ie_o, intent_o, addr_o, wdata_o, be_o, intention_blocks_o and all d_* fields = 0.
- Beat count: beats = max(1, 2^a_size / RegBw).
  - beat address = base + i*RegBw, with base = a_address[RegAw-1:0] with the low log2(RegBw) bits cleared, latched on the first beat.
  - Later beats' a_address is ignored.
  - The beat counter clears after the last beat.
- FSM states: IDLE, ACCESS, WRITE, RESP.
  - a_ready=1 only in IDLE; a beat is accepted on a_valid & a_ready at a clk edge, and opcode/param/size/source/mask/data are latched.
- Get:
  - ACCESS: re_o=1, addr_o=beat address, be_o=mask; capture rdata_i and error_i.
  - RESP: d_valid=1, AccessAckData, d_data=captured data.
  - On d_ready: if beats remain, go to ACCESS with the next address; otherwise IDLE.
  - A burst read needs one A beat and produces N D beats.
- PutFullData/PutPartialData:
  - ACCESS: we_o=1, wdata_o=a_data, be_o=a_mask (PutFull forces all ones).
  - RESP: AccessAck, one per accepted beat, then IDLE.
- ArithmeticData/LogicalData (read-modify-write):
  - ACCESS: re_o=1, capture old value.
  - WRITE: we_o=1, wdata_o=f(old, a_data).
  - RESP: AccessAckData with d_data=old value, one per beat.
  - Arithmetic a_param: 0 MIN signed, 1 MAX signed, 2 MINU, 3 MAXU, 4 ADD (modulo 2^RegDw).
  - Logical a_param: 0 XOR, 1 OR, 2 AND, 3 SWAP.
  - Undefined param: no write, d_error=1.
- Intent:
  - Accept cycle+1: ie_o pulses 1 cycle, intent_o=a_param[0], intention_blocks_o=beats.
  - RESP: HintAck, no register access.
- D channel fields:
  - d_size=latched a_size; d_source=latched a_source; d_param=0; d_sink=0.
  - d_error=captured error_i OR unsupported opcode/param.
  - d_data=0 for AccessAck/HintAck.
  - d_valid holds until d_ready.
- Latency from the acceptance edge:
  - Get/Put: access in cycle 1, d_valid in cycle 2.
  - Atomic: read in cycle 1, write in cycle 2, d_valid in cycle 3.
- re_o and we_o are never both high in the same cycle.
- When re_o=0 and we_o=0, addr_o/wdata_o/be_o hold their last values.
- If error_i=1 during the read phase of an atomic, the write phase is skipped and d_error=1.
- Reset mid-transaction: return immediately to IDLE, drop the outstanding response, clear the beat counter.

Test Plan:
- Get addr 0x0, size 2; register returns 17 -> one AccessAckData, d_data=17, d_size=2, d_source=0.
- Get addr 0x4, size 3 -> re_o at 0x4 then 0x8; two AccessAckData beats with data 1 then 2.
- PutFullData 55 at 0xc, size 2 -> we_o with wdata_o=55, addr_o=0xc; then AccessAck.
- PutFullData size 3, beat 1 data 66 at 0x4, beat 2 data 77 -> we_o 66@0x4 then AccessAck; we_o 77@0x8 with beat 2's a_address ignored.
- ArithmeticData MIN, data 0 at 0x4 (old 1) -> we_o wdata_o=0 @0x4; AccessAckData d_data=1.
- ArithmeticData MAX burst size 3 at 0x4, data 5 then 1 (old values 1 and 2) -> writes 5@0x4 and 2@0x8; responses 1 and 2.
- Intent PrefetchRead, size 2 -> ie_o pulse, intention_blocks_o=1, HintAck, re_o=we_o=0 throughout.
